// File: rtl/disp_pkg.sv
// Shared types and constants for the display arbiter: source count, FSM
// encoding and small helpers for one-hot grants and source data slicing.
package disp_pkg;

    localparam int N_SRC       = 4;
    localparam int SRC_W       = 16;
    localparam int IDX_W       = 2;
    localparam int CNT_W       = 16;
    localparam int DWELL_DEF   = 50000;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    function automatic logic [N_SRC-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return N_SRC'(1) << idx;
    endfunction

    function automatic logic [SRC_W-1:0] src_slice(input logic [N_SRC*SRC_W-1:0] d,
                                                   input logic [IDX_W-1:0]       idx);
        return d[{idx, 4'b0000} +: SRC_W];
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after i_cur, wrapping,
// with i_cur itself searched last.
module rr_pick
    import disp_pkg::*;
(
    input  logic [N_SRC-1:0] i_req,
    input  logic [IDX_W-1:0] i_cur,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_idx   = i_cur;
        o_found = 1'b0;
        w_cand  = i_cur;
        for (int k = 1; k <= N_SRC; k++) begin
            w_cand = IDX_W'(i_cur + IDX_W'(k));
            if (!o_found && i_req[w_cand]) begin
                o_idx   = w_cand;
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/disp_arbiter.sv
// Time-sliced arbiter that hands a 4-digit hex display to one of four sources,
// rotating every DWELL cycles, with lock and immediate hand-off on request drop.
module disp_arbiter
    import disp_pkg::*;
#(
    parameter int unsigned DWELL = DWELL_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_SRC-1:0]       req,
    input  logic [N_SRC*SRC_W-1:0] data,
    input  logic                   lock,
    output logic [SRC_W-1:0]       digit,
    output logic [N_SRC-1:0]       grant,
    output logic [IDX_W-1:0]       owner,
    output logic                   valid
);

    localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [SRC_W-1:0] r_digit;
    logic [N_SRC-1:0] r_grant;
    logic [IDX_W-1:0] r_owner;
    logic             r_valid;

    logic [IDX_W-1:0] w_cur;
    logic [IDX_W-1:0] w_pick;
    logic             w_found;
    logic             w_expire;
    logic             w_own_req;
    logic             w_switch;

    // Searching from index 3 in IDLE turns the rotation order into lowest-index-first.
    assign w_cur     = (r_state == SHOW) ? r_owner : IDX_W'(N_SRC - 1);
    assign w_expire  = (r_cnt == DWELL_M1);
    assign w_own_req = req[r_owner];
    assign w_switch  = !w_own_req || (!lock && w_expire);

    rr_pick u_pick (
        .i_req   (req),
        .i_cur   (w_cur),
        .o_idx   (w_pick),
        .o_found (w_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_digit <= '0;
            r_grant <= '0;
            r_owner <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= SHOW;
                        r_cnt   <= '0;
                        r_owner <= w_pick;
                        r_grant <= idx_onehot(w_pick);
                        r_valid <= 1'b1;
                        r_digit <= src_slice(data, w_pick);
                    end
                end
                SHOW: begin
                    if (!w_found) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_owner <= '0;
                        r_grant <= '0;
                        r_valid <= 1'b0;
                        r_digit <= '0;
                    end else if (w_switch) begin
                        // Dropped request or expiry share one pick; lock cannot hold a dropped owner.
                        r_cnt   <= '0;
                        r_owner <= w_pick;
                        r_grant <= idx_onehot(w_pick);
                        r_digit <= src_slice(data, w_pick);
                    end else begin
                        if (!lock)
                            r_cnt <= r_cnt + CNT_W'(1);
                        r_digit <= src_slice(data, r_owner);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_owner <= '0;
                    r_grant <= '0;
                    r_valid <= 1'b0;
                    r_digit <= '0;
                end
            endcase
        end
    end

    assign digit = r_digit;
    assign grant = r_grant;
    assign owner = r_owner;
    assign valid = r_valid;

endmodule

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 Parameter DWELL, default 50000, SHALL set the number of clk cycles one source owns the display before rotation; legal range 2..65535.
REQ-002 clk  input  1  system clock; every register SHALL update on its rising edge only.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req  input  4  per-source display request; bit i high means source i has a value to show.
REQ-005 data  input  64  packed source values; source i SHALL occupy data[16*i+15:16*i].
REQ-006 lock  input  1  high SHALL freeze rotation on the current owner.
REQ-007 digit  output  16  registered value for the 4-digit hex display driver.
REQ-008 grant  output  4  one-hot owner; all-zero when no owner.
REQ-009 owner  output  2  binary index of the current owner; meaningful only when valid=1.
REQ-010 valid  output  1  high while a source owns the display.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE (no owner) and SHOW (owner held, dwell counter running).
REQ-012 In IDLE with req!=0, the next cycle SHALL enter SHOW with owner set to the lowest-index requester (first grant only).
REQ-013 On entry to SHOW the dwell counter SHALL load 0; it SHALL increment each cycle in SHOW.
REQ-014 Expiry SHALL occur in the cycle the counter equals DWELL-1; from owner o, the next owner SHALL be the first requester in the order o+1, o+2, o+3 (mod 4), then o itself.
REQ-015 Owner index SHALL wrap 3 -> 0.
REQ-016 On expiry with only the owner requesting, owner SHALL stay unchanged and the counter SHALL reload 0.
REQ-017 If req[owner] falls mid-dwell, the next cycle SHALL switch to the next requester per REQ-014, with the counter reloaded to 0, without waiting for expiry.
REQ-018 If req becomes 0 in SHOW, the next cycle SHALL be IDLE with valid=0, grant=0, and digit=16'h0000.
REQ-019 While lock=1 and req[owner]=1, the counter SHALL hold and no rotation SHALL occur; when lock falls, counting SHALL resume from the held value.
REQ-020 lock=1 SHALL NOT hold an owner whose req has fallen; REQ-017 and REQ-018 take precedence.
REQ-021 In SHOW, digit SHALL equal the owner's data slice from the previous cycle (1-cycle latency, live tracking).
REQ-022 In the switch cycle, digit SHALL already show the new owner's data; no cycle SHALL show a mix or stale value.
REQ-023 Simultaneous expiry and owner req fall SHALL follow a single REQ-014 selection.
REQ-024 grant, owner and valid SHALL be registered and mutually consistent in every cycle.

Reset
REQ-025 rst=1 at a clk edge SHALL force state IDLE, counter 0, digit 16'h0000, grant 4'b0000, owner 2'b00, valid 0.
REQ-026 rst asserted mid-SHOW SHALL abort ownership in that same edge; after release, arbitration SHALL restart per REQ-012.
REQ-027 No output SHALL depend on rst combinationally.

Structure
REQ-028 Shared package disp_pkg SHALL hold N_SRC=4, the state encoding (IDLE, SHOW), and the DWELL default constant.
REQ-029 Round-robin selection SHALL live in one combinational sub-module rr_pick (inputs req, current owner; outputs next index and found flag).
REQ-030 The dwell counter SHALL be 16 bits.

Verification (DWELL=4)
REQ-031 Release rst, req=4'b0101, data0=16'h1234, data2=16'hABCD -> owner 0 for 4 cycles with digit=16'h1234, then owner 2 with digit=16'hABCD, then owner 0 again.
REQ-032 Owner 3 and req=4'b1001 at expiry -> owner wraps to 0 and grant=4'b0001.
REQ-033 Owner 1; req[1] drops after 2 cycles, req=4'b0100 -> next cycle owner=2, counter 0.
REQ-034 lock=1 on owner 0 for 20 cycles with req=4'b0011 -> owner stays 0; after lock falls, owner becomes 1 within 4 cycles.
REQ-035 req goes 4'b0010 -> 4'b0000 -> next cycle valid=0, grant=0, digit=16'h0000; rst mid-SHOW -> same reset values in one edge.
